twiddle_seq_gen: RTL and testbench
==================================

Name: twiddle_seq_gen

Overview:
- Parametrised twiddle-factor sequencer for the radix-2 DIT FFT datapath. Generalises the fixed per-stage twiddle tables to any N = 2^LOG2N and any stage.
- On a start pulse it streams the W_N^e coefficients for one stage, one per butterfly, in butterfly order, with ready/valid backpressure.
- Uses a quarter-wave sine ROM with quadrant folding. Supports forward and inverse transforms.

Parameters:
- DATA_W, 14: coefficient width, signed two's complement, 1.0 = 2^(DATA_W-2) (4096 at 14 bit).
- LOG2N, 10: log2 of the FFT size N; legal range 3..12.
- STG_W, 4: stage port width; must satisfy 2^STG_W > LOG2N.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to generate one stage's sequence.
- stage  in  STG_W  stage number s, legal range 1..LOG2N; sampled with start.
- inverse  in  1  0 = forward (W = cos - j sin), 1 = inverse (conjugate); sampled with start.
- busy  out  1  high from the accepted start until the last coefficient is transferred.
- err  out  1  one-cycle pulse when start is rejected for an illegal stage.
- out_valid  out  1  coefficient valid.
- out_ready  in  1  downstream accepts; transfer = out_valid & out_ready.
- cos_data  out  DATA_W  real part.
- sin_data  out  DATA_W  imaginary part.
- tw_exp  out  LOG2N-1  exponent e of the current coefficient.
- out_last  out  1  marks the final coefficient of the stage.

Behaviour:
- Reset: busy, err, out_valid, out_last = 0; cos_data, sin_data, tw_exp = 0; counter and pipeline flushed. Reset mid-sequence aborts immediately; no further outputs.
- Start acceptance:
  - start with busy=0 and 1<=stage<=LOG2N: capture stage and inverse, set busy next cycle.
  - start with busy=0 and stage illegal: err=1 for one cycle, busy stays 0.
  - start while busy=1: ignored, no err.
- Sequence: k runs 0..N/2-1. Exponent e = (k mod 2^(s-1)) * 2^(LOG2N-s), always in [0, N/2).
- ROM: T[i] = round(2^(DATA_W-2) * sin(2*pi*i/N)) for i = 0..N/4 (N/4+1 entries), round half away from zero. Contents are fixed at elaboration.
- Folding, with Q = N/4:
  - e <= Q: c = T[Q-e], s_ = T[e].
  - e > Q: e' = e-Q, c = -T[e'], s_ = T[Q-e'].
- Output mapping:
  - cos_data = c.
  - sin_data = -s_ when inverse=0; +s_ when inverse=1.
  - Magnitudes never exceed 2^(DATA_W-2), so negation cannot overflow.
- Pipeline: 3 registered stages (address/exponent, ROM read, fold/negate).
  - Start accepted at edge t gives first out_valid after edge t+3 when out_ready is held 1.
  - Throughput: 1 coefficient per cycle.
- Backpressure: when out_valid=1 and out_ready=0, the whole pipeline and counter stall. Outputs hold stable; no coefficient is dropped or duplicated.
- out_last is asserted with the coefficient for k = N/2-1. busy falls on the edge that transfers it.
- A new start may be sampled on the first cycle busy=0, i.e. back-to-back stages with one idle cycle.

Test Plan:
- LOG2N=3, stage=3, inverse=0, out_ready=1 -> 4 beats starting cycle 3:
  - (cos,sin) = (4096,0), (2896,-2896), (0,-4096), (-2896,-2896).
  - tw_exp = 0,1,2,3; out_last on beat 4; busy falls on that edge.
- LOG2N=3, stage=1 -> 4 beats of (4096,0). Stage=2 -> tw_exp 0,2,0,2 with (4096,0), (0,-4096) alternating.
- LOG2N=3, stage=3, inverse=1 -> sin values 0, 2896, 4096, 2896; cos unchanged.
- out_ready toggled 1,0,0,1,0,1 during stage 3 -> transferred sequence identical to the unstalled run; data stable while stalled.
- stage=0 and stage=4 (LOG2N=3) -> err pulse, busy=0, no out_valid. start while busy -> ignored and the sequence completes unchanged.
- LOG2N=10, all stages 1..10 -> every beat matches the formula against a real-valued model. Beat count = 512 per stage. rst asserted mid-stage 5 -> all outputs 0 next cycle, and the next start runs cleanly.

Source files
------------

// File: rtl/twiddle_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_seq_gen
// Description : Streams W_N^e twiddle coefficients for one radix-2 DIT FFT
//               stage from a quarter-wave sine ROM with quadrant folding.
// Revision    : 1.0 - initial release
// ============================================================================
module twiddle_seq_gen #(
    parameter int DATA_W = 14,
    parameter int LOG2N  = 10,
    parameter int STG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [STG_W-1:0]         stage,
    input  logic                     inverse,
    output logic                     busy,
    output logic                     err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] cos_data,
    output logic signed [DATA_W-1:0] sin_data,
    output logic [LOG2N-2:0]         tw_exp,
    output logic                     out_last
);

    localparam int               c_ew        = LOG2N - 1;
    localparam int               c_q         = 1 << (LOG2N - 2);
    localparam logic [c_ew-1:0]  c_q_v       = c_ew'(c_q);
    localparam logic [c_ew-1:0]  c_k_last    = '1;
    localparam logic [STG_W-1:0] c_stg_max   = STG_W'(LOG2N);

    localparam logic [1:0]       c_st_idle   = 2'd0;
    localparam logic [1:0]       c_st_run    = 2'd1;
    localparam logic [1:0]       c_st_drain  = 2'd2;

    // round(2^(DATA_W-2) * sin(2*pi*idx/N)) for idx in [0, N/4]; the Taylor
    // series keeps the table a pure elaboration-time constant.
    function automatic int f_quarter_sine(input int idx);
        real x;
        real term;
        real sum;
        real scale;
        x    = 2.0 * 3.14159265358979323846 * real'(idx) / real'(1 << LOG2N);
        sum  = x;
        term = x;
        for (int n = 1; n < 16; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        scale = real'(1 << (DATA_W - 2));
        return $rtoi(sum * scale + 0.5);
    endfunction

    logic signed [DATA_W-1:0] w_rom [0:c_q];

    genvar gi;
    generate
        for (gi = 0; gi <= c_q; gi++) begin : g_rom
            assign w_rom[gi] = DATA_W'(f_quarter_sine(gi));
        end
    endgenerate

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [STG_W-1:0]         r_stage;
    logic                     r_inv;
    logic [c_ew-1:0]          r_k;
    logic                     r_err;

    logic                     r_v1;
    logic                     r_l1;
    logic                     r_neg1;
    logic [c_ew-1:0]          r_e1;
    logic [c_ew-1:0]          r_ac1;
    logic [c_ew-1:0]          r_as1;

    logic                     r_v2;
    logic                     r_l2;
    logic                     r_neg2;
    logic [c_ew-1:0]          r_e2;
    logic signed [DATA_W-1:0] r_c2;
    logic signed [DATA_W-1:0] r_s2;

    logic                     r_v3;
    logic                     r_l3;
    logic [c_ew-1:0]          r_e3;
    logic signed [DATA_W-1:0] r_c3;
    logic signed [DATA_W-1:0] r_s3;

    logic                     w_legal;
    logic                     w_accept;
    logic                     w_adv;
    logic                     w_issue;
    logic                     w_xfer;
    logic [c_ew-1:0]          w_mask;
    logic [STG_W-1:0]         w_shift;
    logic [c_ew-1:0]          w_e;
    logic                     w_fold;
    logic [c_ew-1:0]          w_ep;
    logic [c_ew-1:0]          w_ac;
    logic [c_ew-1:0]          w_as;

    assign w_legal  = (stage != '0) && (stage <= c_stg_max);
    assign w_accept = start && (r_state == c_st_idle) && w_legal;
    // A single enable freezes counter and every pipeline stage under backpressure.
    assign w_adv    = !r_v3 || out_ready;
    assign w_issue  = (r_state == c_st_run) && w_adv;
    assign w_xfer   = r_v3 && out_ready;

    // e = (k mod 2^(s-1)) * 2^(LOG2N-s)
    assign w_mask  = ~({c_ew{1'b1}} << (r_stage - STG_W'(1)));
    assign w_shift = c_stg_max - r_stage;
    assign w_e     = (r_k & w_mask) << w_shift;

    assign w_fold  = (w_e > c_q_v);
    assign w_ep    = w_e - c_q_v;
    assign w_ac    = w_fold ? w_ep : (c_q_v - w_e);
    assign w_as    = w_fold ? (c_q_v - w_ep) : w_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                if (w_issue && (r_k == c_k_last)) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_xfer && r_l3) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
            r_inv   <= 1'b0;
            r_k     <= '0;
            r_err   <= 1'b0;
            r_v1    <= 1'b0;
            r_l1    <= 1'b0;
            r_neg1  <= 1'b0;
            r_e1    <= '0;
            r_ac1   <= '0;
            r_as1   <= '0;
            r_v2    <= 1'b0;
            r_l2    <= 1'b0;
            r_neg2  <= 1'b0;
            r_e2    <= '0;
            r_c2    <= '0;
            r_s2    <= '0;
            r_v3    <= 1'b0;
            r_l3    <= 1'b0;
            r_e3    <= '0;
            r_c3    <= '0;
            r_s3    <= '0;
        end else begin
            r_err <= start && (r_state == c_st_idle) && !w_legal;

            if (w_accept) begin
                r_stage <= stage;
                r_inv   <= inverse;
                r_k     <= '0;
            end else if (w_issue) begin
                r_k     <= r_k + c_ew'(1);
            end

            if (w_adv) begin
                r_v1   <= w_issue;
                r_l1   <= (r_k == c_k_last);
                r_neg1 <= w_fold;
                r_e1   <= w_e;
                r_ac1  <= w_ac;
                r_as1  <= w_as;

                r_v2   <= r_v1;
                r_l2   <= r_l1;
                r_neg2 <= r_neg1;
                r_e2   <= r_e1;
                r_c2   <= w_rom[r_ac1];
                r_s2   <= w_rom[r_as1];

                r_v3   <= r_v2;
                r_l3   <= r_l2;
                r_e3   <= r_e2;
                r_c3   <= r_neg2 ? -r_c2 : r_c2;
                r_s3   <= r_inv ? r_s2 : -r_s2;
            end
        end
    end

    assign busy      = (r_state != c_st_idle);
    assign err       = r_err;
    assign out_valid = r_v3;
    assign out_last  = r_l3;
    assign cos_data  = r_c3;
    assign sin_data  = r_s3;
    assign tw_exp    = r_e3;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_twiddle_seq_gen
// Description : Scoreboard bench for twiddle_seq_gen at LOG2N=3 and LOG2N=10.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twiddle_seq_gen;

    localparam int  DATA_W = 14;
    localparam int  STG_W  = 4;
    localparam real c_pi   = 3.14159265358979323846;

    typedef struct {
        int c;
        int s;
        int e;
        bit l;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [1:0]             r_start;
    logic [1:0]             r_inv;
    logic [1:0]             r_ready;
    logic [1:0][STG_W-1:0]  r_stage;
    wire  [1:0]             w_busy;
    wire  [1:0]             w_err;
    wire  [1:0]             w_valid;
    wire  [1:0]             w_last;
    wire  [1:0][DATA_W-1:0] w_cos;
    wire  [1:0][DATA_W-1:0] w_sin;
    wire  [1:0][10:0]       w_exp;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    rdy_mode [2];
    beat_t q0 [$];
    beat_t q1 [$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int c_l = (gi == 0) ? 3 : 10;
        wire [c_l-2:0] w_e;
        twiddle_seq_gen #(.DATA_W(DATA_W), .LOG2N(c_l), .STG_W(STG_W)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (r_start[gi]),
            .stage     (r_stage[gi]),
            .inverse   (r_inv[gi]),
            .busy      (w_busy[gi]),
            .err       (w_err[gi]),
            .out_valid (w_valid[gi]),
            .out_ready (r_ready[gi]),
            .cos_data  (w_cos[gi]),
            .sin_data  (w_sin[gi]),
            .tw_exp    (w_e),
            .out_last  (w_last[gi])
        );
        assign w_exp[gi] = 11'(w_e);
    end

    function automatic void chk(string name, int d, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, act, exp, $time);
        end
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void push(int d, beat_t b);
        if (d == 0) q0.push_back(b);
        else        q1.push_back(b);
    endfunction

    function automatic beat_t pop(int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic int f_rnd(real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    // Reference: exact trigonometry on the exponent, no table or folding.
    function automatic beat_t f_model(int l2n, int s, bit inv, int k);
        beat_t b;
        real   th;
        real   amp;
        int    sv;
        b.e = (k % (1 << (s - 1))) * (1 << (l2n - s));
        th  = 2.0 * c_pi * real'(b.e) / real'(1 << l2n);
        amp = real'(1 << (DATA_W - 2));
        b.c = f_rnd(amp * $cos(th));
        sv  = f_rnd(amp * $sin(th));
        b.s = inv ? sv : -sv;
        b.l = (k == (1 << (l2n - 1)) - 1);
        return b;
    endfunction

    task automatic push_model(int d, int s, bit inv);
        int l2n;
        l2n = (d == 0) ? 3 : 10;
        for (int k = 0; k < (1 << (l2n - 1)); k++) push(d, f_model(l2n, s, inv, k));
    endtask

    task automatic launch(int d, int s, bit inv);
        r_start[d] = 1'b1;
        r_stage[d] = STG_W'(s);
        r_inv[d]   = inv;
        @(posedge clk); #1;
        r_start[d] = 1'b0;
    endtask

    task automatic wait_done(int d, int budget);
        int n;
        n = 0;
        while ((qsize(d) != 0 || w_busy[d]) && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        chk("done_within_budget", d, longint'(n < budget), 1);
    endtask

    // Ready driver: 0 = always ready, 1 = fixed 1,0,0,1,0,1 pattern, 2 = random.
    initial begin
        int pat [6];
        int pidx;
        pat     = '{1, 0, 0, 1, 0, 1};
        pidx    = 0;
        r_ready = 2'b11;
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                case (rdy_mode[d])
                    1:       r_ready[d] = pat[pidx % 6][0];
                    2:       r_ready[d] = ($urandom_range(0, 3) != 0);
                    default: r_ready[d] = 1'b1;
                endcase
            end
            pidx++;
        end
    end

    // Monitor: pops the scoreboard on every transfer and checks hold under stall.
    initial begin
        bit    prev_stall [2];
        bit    busy_low   [2];
        beat_t snap       [2];
        beat_t exp_b;
        prev_stall = '{0, 0};
        busy_low   = '{0, 0};
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    prev_stall[d] = 0;
                    busy_low[d]   = 0;
                end else begin
                    if (busy_low[d]) begin
                        chk("busy_after_last", d, longint'(w_busy[d]), 0);
                        busy_low[d] = 0;
                    end
                    if (prev_stall[d]) begin
                        chk("stall_valid_hold", d, longint'(w_valid[d]), 1);
                        chk("stall_cos_hold", d, $signed(w_cos[d]), snap[d].c);
                        chk("stall_sin_hold", d, $signed(w_sin[d]), snap[d].s);
                        chk("stall_exp_hold", d, longint'(w_exp[d]), snap[d].e);
                    end
                    prev_stall[d] = 0;
                    if (w_valid[d]) begin
                        if (r_ready[d]) begin
                            if (qsize(d) == 0) begin
                                chk("unexpected_beat", d, 1, 0);
                            end else begin
                                exp_b = pop(d);
                                chk("cos_data", d, $signed(w_cos[d]), exp_b.c);
                                chk("sin_data", d, $signed(w_sin[d]), exp_b.s);
                                chk("tw_exp", d, longint'(w_exp[d]), exp_b.e);
                                chk("out_last", d, longint'(w_last[d]), longint'(exp_b.l));
                                chk("busy_during_beat", d, longint'(w_busy[d]), 1);
                                busy_low[d] = exp_b.l;
                            end
                        end else begin
                            prev_stall[d] = 1;
                            snap[d].c = $signed(w_cos[d]);
                            snap[d].s = $signed(w_sin[d]);
                            snap[d].e = int'(w_exp[d]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int    tc [4];
        int    ts [4];
        beat_t b;
        tc       = '{4096, 2896, 0, -2896};
        ts       = '{0, -2896, -4096, -2896};
        rdy_mode = '{0, 0};
        rst      = 1'b1;
        r_start  = '0;
        r_inv    = '0;
        r_stage  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", d, longint'(w_busy[d]), 0);
            chk("rst_err", d, longint'(w_err[d]), 0);
            chk("rst_valid", d, longint'(w_valid[d]), 0);
            chk("rst_last", d, longint'(w_last[d]), 0);
            chk("rst_cos", d, longint'(w_cos[d]), 0);
            chk("rst_sin", d, longint'(w_sin[d]), 0);
            chk("rst_exp", d, longint'(w_exp[d]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Stage 3 forward with known constants and first-beat latency.
        for (int k = 0; k < 4; k++) begin
            b.c = tc[k]; b.s = ts[k]; b.e = k; b.l = (k == 3);
            push(0, b);
        end
        r_start[0] = 1'b1; r_stage[0] = 4'd3; r_inv[0] = 1'b0;
        @(posedge clk); #1;
        r_start[0] = 1'b0;
        chk("busy_after_start", 0, longint'(w_busy[0]), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("valid_before_latency", 0, longint'(w_valid[0]), 0);
        @(posedge clk); #1;
        chk("valid_at_latency", 0, longint'(w_valid[0]), 1);
        wait_done(0, 50);

        // Back-to-back stages, forward and inverse.
        push_model(0, 1, 1'b0); launch(0, 1, 1'b0); wait_done(0, 50);
        push_model(0, 2, 1'b0); launch(0, 2, 1'b0); wait_done(0, 50);
        push_model(0, 3, 1'b1); launch(0, 3, 1'b1); wait_done(0, 50);

        // Stalled run must transfer the same sequence.
        rdy_mode[0] = 1;
        for (int k = 0; k < 4; k++) begin
            b.c = tc[k]; b.s = ts[k]; b.e = k; b.l = (k == 3);
            push(0, b);
        end
        launch(0, 3, 1'b0); wait_done(0, 80);
        rdy_mode[0] = 2;
        push_model(0, 2, 1'b1); launch(0, 2, 1'b1); wait_done(0, 80);
        rdy_mode[0] = 0;

        // Illegal stages pulse err and start nothing.
        for (int i = 0; i < 2; i++) begin
            r_start[0] = 1'b1; r_stage[0] = (i == 0) ? 4'd0 : 4'd4;
            @(posedge clk); #1;
            r_start[0] = 1'b0;
            chk("err_pulse", 0, longint'(w_err[0]), 1);
            chk("err_busy", 0, longint'(w_busy[0]), 0);
            @(posedge clk); #1;
            chk("err_one_cycle", 0, longint'(w_err[0]), 0);
            chk("err_no_busy", 0, longint'(w_busy[0]), 0);
        end

        // Starts while busy are ignored, legal or not.
        push_model(0, 2, 1'b1); launch(0, 2, 1'b1);
        r_start[0] = 1'b1; r_stage[0] = 4'd1; r_inv[0] = 1'b0;
        @(posedge clk); #1;
        r_stage[0] = 4'd0;
        @(posedge clk); #1;
        r_start[0] = 1'b0;
        chk("busy_start_no_err", 0, longint'(w_err[0]), 0);
        wait_done(0, 50);

        // LOG2N=10: every stage with random inverse and random backpressure.
        rdy_mode[1] = 2;
        for (int s = 1; s <= 10; s++) begin
            bit inv;
            inv = 1'($urandom_range(0, 1));
            push_model(1, s, inv);
            launch(1, s, inv);
            wait_done(1, 5000);
        end

        // Reset in the middle of stage 5, then a clean rerun.
        push_model(1, 5, 1'b0);
        launch(1, 5, 1'b0);
        repeat (150) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        q1.delete();
        rst = 1'b0;
        chk("midrst_busy", 1, longint'(w_busy[1]), 0);
        chk("midrst_valid", 1, longint'(w_valid[1]), 0);
        chk("midrst_last", 1, longint'(w_last[1]), 0);
        chk("midrst_cos", 1, longint'(w_cos[1]), 0);
        chk("midrst_sin", 1, longint'(w_sin[1]), 0);
        chk("midrst_exp", 1, longint'(w_exp[1]), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_quiet", 1, longint'(w_valid[1]), 0);
        push_model(1, 5, 1'b1); launch(1, 5, 1'b1); wait_done(1, 5000);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
